dict_hamming_decompressor: RTL
==============================

DICT_HAMMING_DECOMPRESSOR -- requirements
Module: dict_hamming_decompressor

Interface
REQ-001 SHALL have parameter CHUNK_SIZE, default 4, bits per codeword.
REQ-002 SHALL have parameter CODEBOOK_SIZE, default 8, number of codebook entries.
REQ-003 SHALL have parameter NUM_CHUNKS, default 32, chunks per frame.
REQ-004 SHALL derive localparams INDEX_BITS = $clog2(CODEBOOK_SIZE) and STREAM_LENGTH = NUM_CHUNKS*CHUNK_SIZE.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port compressed_in, input, NUM_CHUNKS*INDEX_BITS, packed indices; chunk k at [k*INDEX_BITS +: INDEX_BITS].
REQ-008 SHALL have port load, input, 1, frame-load strobe.
REQ-009 SHALL have port busy, output, 1, high while serializing.
REQ-010 SHALL have port data_out, output, 1, reconstructed bit.
REQ-011 SHALL have port data_valid_out, output, 1, data_out qualifier.
REQ-012 SHALL have port decompression_done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; reset state is IDLE.
REQ-014 SHALL sample compressed_in into an internal frame register on a rising edge where load=1 in IDLE or DONE, then enter RUN.
REQ-015 SHALL ignore load while in RUN; the frame register and the stream are unaffected.
REQ-016 SHALL emit one bit per cycle in RUN: chunk 0 first, then chunks in ascending order; each chunk MSB first.
REQ-017 SHALL produce each chunk as codebook[index] from the shared package; an index >= CODEBOOK_SIZE decodes to all-zeros.
REQ-018 SHALL register data_out and data_valid_out; the first bit is valid in the cycle after the load edge, and STREAM_LENGTH consecutive valid bits follow with no gaps.
REQ-019 SHALL track position with a bit-in-chunk counter ($clog2(CHUNK_SIZE) bits) and a chunk counter ($clog2(NUM_CHUNKS) bits); both wrap to 0 at the end of the frame.
REQ-020 SHALL move RUN->DONE after the last bit; in DONE, decompression_done=1 for exactly one cycle, data_valid_out=0 and busy=0.
REQ-021 SHALL move DONE->IDLE when load=0, or DONE->RUN when load=1, giving exactly one idle cycle between back-to-back frames.
REQ-022 SHALL hold data_out at 0 whenever data_valid_out=0.

Reset
REQ-023 SHALL, on rst_n low at any time, including mid-frame, force IDLE and clear the frame register, both counters, busy, data_out, data_valid_out, decompression_done and ones_count to 0.
REQ-024 SHALL NOT pulse decompression_done for a frame that was aborted by reset.

Configuration
REQ-025 SHALL, when DICT_DECOMP_ONES_COUNT_EN is defined, add output ones_count [$clog2(STREAM_LENGTH+1)-1:0].
REQ-026 With the macro defined, ones_count SHALL clear on load, increment on each valid 1 bit, and hold from DONE until the next load.
REQ-027 SHALL, when DICT_DECOMP_ONES_COUNT_EN is not defined, have neither the port nor the counter logic.

Structure
REQ-028 SHALL import the package dict_hamming_pkg, which holds the CODEBOOK constant array shared with the compressor.
REQ-029 CODEBOOK (4-bit, 8 entries), indices 0..7: 0000, 0001, 0011, 0111, 1111, 1000, 1100, 1110.
REQ-030 SHALL place the codeword lookup in one sub-module, dict_hamming_lookup, which is combinational: index to chunk.

Verification
REQ-031 Bench SHALL cover: compressed_in all-zero, load pulsed at cycle 0 -> 128 zero bits valid in cycles 1..128, decompression_done pulses in cycle 129.
REQ-032 Bench SHALL cover: chunk k index = k mod 8 -> stream is 0000 0001 0011 0111 1111 1000 1100 1110 repeated 4x; with the macro, ones_count = 64.
REQ-033 Bench SHALL cover: load re-pulsed with a different frame at bit 40 -> ignored; the original 128 bits complete unchanged.
REQ-034 Bench SHALL cover: rst_n low at bit 50 -> all outputs 0 at once; no done pulse; a subsequent load starts a clean frame.
REQ-035 Bench SHALL cover: load held high during the DONE cycle -> the second frame's first bit is valid in the next cycle.
REQ-036 Bench SHALL cover: loopback compressor->decompressor with a 128-bit stream built only from codebook words -> output stream is bit-identical to the input.

Source files
------------

// File: rtl/dict_hamming_pkg.sv
// Shared dictionary for the Hamming-style chunk compressor/decompressor pair.
// Holds the codebook constant and the decompressor FSM encodings.
package dict_hamming_pkg;

   localparam int CB_WIDTH   = 4;
   localparam int CB_ENTRIES = 8;

   localparam logic [CB_WIDTH-1:0] CODEBOOK [CB_ENTRIES] = '{
      4'b0000, 4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1000, 4'b1100, 4'b1110
   };

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/dict_hamming_lookup.sv
// Combinational codeword lookup: dictionary index to chunk bits.
// Indices beyond the codebook decode to all-zeros.
module dict_hamming_lookup
   import dict_hamming_pkg::*;
#(
   parameter int CHUNK_SIZE    = 4,
   parameter int CODEBOOK_SIZE = 8,
   parameter int INDEX_BITS    = 3
) (
   input  logic [INDEX_BITS-1:0] index,
   output logic [CHUNK_SIZE-1:0] chunk
);

   always_comb begin
      chunk = '0;
      if (int'(index) < CODEBOOK_SIZE && int'(index) < CB_ENTRIES)
         chunk = CHUNK_SIZE'(CODEBOOK[index]);
   end

endmodule

// File: rtl/dict_hamming_decompressor.sv
// Frame decompressor: expands packed codebook indices into a serial bit stream.
// Optional ones_count output enabled by defining DICT_DECOMP_ONES_COUNT_EN.
module dict_hamming_decompressor
   import dict_hamming_pkg::*;
#(
   parameter int CHUNK_SIZE    = 4,
   parameter int CODEBOOK_SIZE = 8,
   parameter int NUM_CHUNKS    = 32
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [NUM_CHUNKS*$clog2(CODEBOOK_SIZE)-1:0]  compressed_in,
   input  logic                                         load,
   output logic                                         busy,
   output logic                                         data_out,
   output logic                                         data_valid_out,
   output logic                                         decompression_done
`ifdef DICT_DECOMP_ONES_COUNT_EN
   ,
   output logic [$clog2(NUM_CHUNKS*CHUNK_SIZE+1)-1:0]   ones_count
`endif
);

   localparam int INDEX_BITS    = $clog2(CODEBOOK_SIZE);
   localparam int STREAM_LENGTH = NUM_CHUNKS * CHUNK_SIZE;
   localparam int BIT_W         = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
   localparam int CHK_W         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   logic [1:0]                       state;
   logic [NUM_CHUNKS*INDEX_BITS-1:0] frame;
   logic [BIT_W-1:0]                 bit_cnt, next_bit;
   logic [CHK_W-1:0]                 chunk_cnt, next_chunk;
   logic                             start, last_bit;
   logic [INDEX_BITS-1:0]            index;
   logic [CHUNK_SIZE-1:0]            chunk;
   logic                             next_data;

   assign start    = load && (state != S_RUN);
   assign last_bit = (bit_cnt == BIT_W'(CHUNK_SIZE-1)) && (chunk_cnt == CHK_W'(NUM_CHUNKS-1));
   assign busy     = (state == S_RUN);

   // Counters hold the position currently on data_out; the lookup works one
   // bit ahead so the output register always carries the next bit in time.
   always_comb begin
      next_bit   = '0;
      next_chunk = '0;
      if (!start && !last_bit) begin
         if (bit_cnt == BIT_W'(CHUNK_SIZE-1)) begin
            next_chunk = chunk_cnt + 1'b1;
         end else begin
            next_chunk = chunk_cnt;
            next_bit   = bit_cnt + 1'b1;
         end
      end
   end

   assign index = start ? compressed_in[INDEX_BITS-1:0]
                        : frame[int'(next_chunk)*INDEX_BITS +: INDEX_BITS];

   dict_hamming_lookup #(
      .CHUNK_SIZE    (CHUNK_SIZE),
      .CODEBOOK_SIZE (CODEBOOK_SIZE),
      .INDEX_BITS    (INDEX_BITS)
   ) u_lookup (
      .index (index),
      .chunk (chunk)
   );

   assign next_data = chunk[BIT_W'(CHUNK_SIZE-1) - next_bit];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= S_IDLE;
         frame              <= '0;
         bit_cnt            <= '0;
         chunk_cnt          <= '0;
         data_out           <= 1'b0;
         data_valid_out     <= 1'b0;
         decompression_done <= 1'b0;
      end else begin
         bit_cnt   <= next_bit;
         chunk_cnt <= next_chunk;
         case (state)
            S_IDLE, S_DONE: begin
               decompression_done <= 1'b0;
               if (load) begin
                  frame          <= compressed_in;
                  state          <= S_RUN;
                  data_out       <= next_data;
                  data_valid_out <= 1'b1;
               end else begin
                  state          <= S_IDLE;
                  data_out       <= 1'b0;
                  data_valid_out <= 1'b0;
               end
            end
            S_RUN: begin
               if (last_bit) begin
                  state              <= S_DONE;
                  data_out           <= 1'b0;
                  data_valid_out     <= 1'b0;
                  decompression_done <= 1'b1;
               end else begin
                  data_out <= next_data;
               end
            end
            default: begin
               state              <= S_IDLE;
               data_out           <= 1'b0;
               data_valid_out     <= 1'b0;
               decompression_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef DICT_DECOMP_ONES_COUNT_EN
   // Counts the registered output, so the last bit lands on the RUN->DONE edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ones_count <= '0;
      else if (start)
         ones_count <= '0;
      else if (data_valid_out && data_out)
         ones_count <= ones_count + 1'b1;
   end
`endif

   logic unused_ok;
   assign unused_ok = (STREAM_LENGTH == 0);

endmodule
